// File: rtl/sum_group_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// sum_group_accumulator_pkg
// Shared flow-control definitions for the sum-group accumulator:
//   - state_e       : controller state (ACCUM collecting, HOLD presenting)
//   - calc_cnt_w()  : width of the item counter / out_count for a group size
//   - calc_acc_w()  : accumulator width wide enough for a full group of
//                     maximum-value sums, so the total can never overflow
// -----------------------------------------------------------------------------
package sum_group_accumulator_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Counter must represent the value group_max itself (reported in out_count).
  function automatic int calc_cnt_w(input int group_max);
    return $clog2(group_max + 1);
  endfunction

  // Each item is width+1 bits; summing group_max of them adds clog2(group_max)
  // bits of headroom.
  function automatic int calc_acc_w(input int width, input int group_max);
    return width + 1 + $clog2(group_max);
  endfunction

endpackage : sum_group_accumulator_pkg

// File: rtl/sum_group_accumulator.sv
// -----------------------------------------------------------------------------
// sum_group_accumulator
// Consumes the adder's valid/ready sum stream, adds consecutive sums into
// groups, and presents one registered total per group on a valid/ready output.
// A group closes after group_max accepted items, or earlier on an item flagged
// in_last. out_data/out_count come straight from registers; the only
// combinational in->out path is ready (in_rdy follows out_rdy while a total is
// held) so a new group can start in the same cycle the old total leaves.
//
// Ports
//   clk        clock
//   rst        synchronous, active-low reset
//   in_vld     upstream sum valid
//   in_rdy     upstream sum ready
//   in_data    upstream sum (width+1 bits)
//   in_last    closes the current group early (qualified by in_vld)
//   out_vld    group total valid
//   out_rdy    downstream ready
//   out_data   group total, zero-extended (acc_w bits)
//   out_count  number of items in the emitted group, 1..group_max
// -----------------------------------------------------------------------------
module sum_group_accumulator
  import sum_group_accumulator_pkg::*;
#(
  parameter  int width     = 8,
  parameter  int group_max = 4,
  localparam int cnt_w     = calc_cnt_w(group_max),
  localparam int acc_w     = calc_acc_w(width, group_max)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [width:0]   in_data,
  input  logic             in_last,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [acc_w-1:0] out_data,
  output logic [cnt_w-1:0] out_count
);

  state_e           state_q, state_d;
  logic [acc_w-1:0] acc_q, acc_d;
  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic [acc_w-1:0] out_data_q, out_data_d;
  logic [cnt_w-1:0] out_count_q, out_count_d;

  logic             accept;
  logic             closes;
  logic [acc_w-1:0] sum;
  logic [cnt_w-1:0] cnt_inc;

  assign out_vld   = (state_q == HOLD);
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

  // While holding, an item may only enter if the held total leaves this cycle.
  assign in_rdy = (state_q == ACCUM) || out_rdy;
  assign accept = in_vld && in_rdy;

  // acc/cnt are cleared when a group closes, so in HOLD they are already zero
  // and the same sum/count expressions start the next group correctly.
  assign sum     = acc_q + acc_w'(in_data);
  assign cnt_inc = cnt_q + cnt_w'(1);
  // A last-flagged group_max-th item satisfies both terms but closes once.
  assign closes  = in_last || (cnt_inc == cnt_w'(group_max));

  // NOTE: every variable gets its hold value first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;

    // The held total leaves on transfer; a closing item below re-enters HOLD.
    if (state_q == HOLD && out_rdy) begin
      state_d = ACCUM;
    end

    if (accept) begin
      if (closes) begin
        out_data_d  = sum;
        out_count_d = cnt_inc;
        acc_d       = '0;
        cnt_d       = '0;
        state_d     = HOLD;
      end else begin
        acc_d = sum;
        cnt_d = cnt_inc;
      end
    end
  end

  // NOTE: every register here has a defined reset value so a reset mid-group
  // or mid-HOLD discards partial and pending data completely.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same
      // pre-edge values.
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  // A stalled total must stay valid and unchanged until it is taken.
  assert property (@(posedge clk)
    rst && out_vld && !out_rdy |=> out_vld && $stable(out_data) && $stable(out_count));

  // The counter never reaches group_max while collecting.
  assert property (@(posedge clk)
    rst && (state_q == ACCUM) |-> (cnt_q < cnt_w'(group_max)));

endmodule : sum_group_accumulator

// File: tb/tb_sum_group_accumulator.sv
// -----------------------------------------------------------------------------
// tb_sum_group_accumulator
// Directed bench: a table of {inputs, expected outputs} records applied to a
// group_max=4 instance, hand-written sequences for reset mid-group / mid-HOLD,
// and a group_max=1 instance for sustained single-item groups.
// Inputs change 1 ns after the rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_sum_group_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // group_max = 4 instance (acc_w = 11, cnt_w = 3)
  logic        in_vld, in_last, out_rdy;
  logic [8:0]  in_data;
  logic        in_rdy, out_vld;
  logic [10:0] out_data;
  logic [2:0]  out_count;

  // group_max = 1 instance (acc_w = 9, cnt_w = 1)
  logic        in_vld1, in_last1, out_rdy1;
  logic [8:0]  in_data1;
  logic        in_rdy1, out_vld1;
  logic [8:0]  out_data1;
  logic [0:0]  out_count1;

  sum_group_accumulator #(.width(8), .group_max(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .out_data  (out_data),
    .out_count (out_count)
  );

  sum_group_accumulator #(.width(8), .group_max(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_vld    (in_vld1),
    .in_rdy    (in_rdy1),
    .in_data   (in_data1),
    .in_last   (in_last1),
    .out_vld   (out_vld1),
    .out_rdy   (out_rdy1),
    .out_data  (out_data1),
    .out_count (out_count1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One record per cycle: inputs driven, in_rdy expected in that cycle,
  // outputs expected after the following edge (data/count only when valid).
  typedef struct {
    logic        vld;
    logic [8:0]  data;
    logic        last;
    logic        ordy;
    logic        exp_rdy;
    logic        exp_vld;
    logic [10:0] exp_data;
    logic [2:0]  exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic vld, input int data, input logic last,
                              input logic ordy, input logic exp_rdy,
                              input logic exp_vld, input int exp_data, input int exp_cnt);
    vec_t v;
    v.vld      = vld;
    v.data     = 9'(data);
    v.last     = last;
    v.ordy     = ordy;
    v.exp_rdy  = exp_rdy;
    v.exp_vld  = exp_vld;
    v.exp_data = 11'(exp_data);
    v.exp_cnt  = 3'(exp_cnt);
    vecs.push_back(v);
  endfunction

  initial begin
    rst      = 1'b0;
    in_vld   = 1'b0; in_data  = '0; in_last  = 1'b0; out_rdy  = 1'b1;
    in_vld1  = 1'b0; in_data1 = '0; in_last1 = 1'b0; out_rdy1 = 1'b1;

    //   vld data last ordy | rdy vld data cnt
    // full group of four, one total the cycle after the 4th accept
    add(1,  10, 0, 1,   1, 0,    0, 0);
    add(1,  20, 0, 1,   1, 0,    0, 0);
    add(1,  30, 0, 1,   1, 0,    0, 0);
    add(1,  40, 0, 1,   1, 1,  100, 4);
    // maximum sums, first item accepted during the HOLD transfer (no bubble)
    add(1, 511, 0, 1,   1, 0,    0, 0);
    add(1, 511, 0, 1,   1, 0,    0, 0);
    add(1, 511, 0, 1,   1, 0,    0, 0);
    add(1, 511, 0, 1,   1, 1, 2044, 4);
    // early close on in_last
    add(1,   5, 0, 1,   1, 0,    0, 0);
    add(1,   7, 1, 1,   1, 1,   12, 2);
    add(0,   0, 0, 1,   1, 0,    0, 0);
    // next group starts from zero
    add(1,   1, 1, 1,   1, 1,    1, 1);
    // downstream stall for 5 cycles: in_rdy low, offered data ignored
    for (int i = 0; i < 5; i++) add(1, 99, 1, 0, 0, 1, 1, 1);
    // release together with input 3: transfer plus new group (acc=3, cnt=1)
    add(1,   3, 0, 1,   1, 0,    0, 0);
    add(1,   4, 1, 1,   1, 1,    7, 2);
    // transfer with a closing accept: reload and stay in HOLD
    add(1,   2, 1, 1,   1, 1,    2, 1);
    add(1,   8, 1, 0,   0, 1,    2, 1);
    add(0,   0, 0, 1,   1, 0,    0, 0);
    // in_last on the group_max-th item closes exactly one group
    add(1,   1, 0, 1,   1, 0,    0, 0);
    add(1,   1, 0, 1,   1, 0,    0, 0);
    add(1,   1, 0, 1,   1, 0,    0, 0);
    add(1,   1, 1, 1,   1, 1,    4, 4);
    add(0,   0, 0, 1,   1, 0,    0, 0);
    add(0,   0, 0, 1,   1, 0,    0, 0);

    // reset state
    repeat (3) step();
    rst = 1'b1;
    check("reset out_vld",   32'(out_vld),   0);
    check("reset out_data",  32'(out_data),  0);
    check("reset out_count", 32'(out_count), 0);
    check("reset in_rdy",    32'(in_rdy),    1);

    foreach (vecs[i]) begin
      in_vld  = vecs[i].vld;
      in_data = vecs[i].data;
      in_last = vecs[i].last;
      out_rdy = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d in_rdy", i), 32'(in_rdy), 32'(vecs[i].exp_rdy));
      step();
      check($sformatf("vec%0d out_vld", i), 32'(out_vld), 32'(vecs[i].exp_vld));
      if (vecs[i].exp_vld) begin
        check($sformatf("vec%0d out_data", i),  32'(out_data),  32'(vecs[i].exp_data));
        check($sformatf("vec%0d out_count", i), 32'(out_count), 32'(vecs[i].exp_cnt));
      end
    end

    // reset after two items (9, 9): partial sum discarded
    in_vld = 1'b1; in_last = 1'b0; out_rdy = 1'b1; in_data = 9'd9;
    step();
    step();
    in_vld = 1'b0;
    rst    = 1'b0;
    step();
    rst = 1'b1;
    check("midgrp rst out_vld",   32'(out_vld),   0);
    check("midgrp rst out_data",  32'(out_data),  0);
    check("midgrp rst out_count", 32'(out_count), 0);
    in_vld = 1'b1; in_data = 9'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("resume item%0d out_vld", i), 32'(out_vld), 0);
    end
    step();
    in_vld = 1'b0;
    check("resume out_vld",   32'(out_vld),   1);
    check("resume out_data",  32'(out_data),  4);
    check("resume out_count", 32'(out_count), 4);

    // reset while a total is held and stalled: pending total discarded
    out_rdy = 1'b0;
    rst     = 1'b0;
    step();
    rst     = 1'b1;
    out_rdy = 1'b1;
    check("midhold rst out_vld",   32'(out_vld),   0);
    check("midhold rst out_count", 32'(out_count), 0);
    step();
    check("midhold after out_vld", 32'(out_vld), 0);

    // group_max = 1: every item is its own group, one per cycle
    in_vld1 = 1'b1; in_last1 = 1'b0; out_rdy1 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      in_data1 = 9'(k);
      #1;
      check($sformatf("gm1 item%0d in_rdy", k), 32'(in_rdy1), 1);
      step();
      check($sformatf("gm1 item%0d out_vld", k),   32'(out_vld1),   1);
      check($sformatf("gm1 item%0d out_data", k),  32'(out_data1),  32'(k));
      check($sformatf("gm1 item%0d out_count", k), 32'(out_count1), 1);
    end
    in_vld1 = 1'b0;
    step();
    check("gm1 drain out_vld", 32'(out_vld1), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_sum_group_accumulator
